// File: rtl/imem_refill_if.sv
// Request/ROM bundle between the icache miss logic, the refill controller
// and the instruction ROM.
//   req_valid_i / req_addr_i / req_ready_o : miss request handshake
//   mem_addr_o / mem_inst_i                : combinational-read ROM port
// The slave modport is the refill controller's view; master is the other side.
interface imem_refill_if;
  logic        req_valid_i;
  logic [31:0] req_addr_i;
  logic        req_ready_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_inst_i;

  modport slave (
    input  req_valid_i, req_addr_i, mem_inst_i,
    output req_ready_o, mem_addr_o
  );

  modport master (
    output req_valid_i, req_addr_i, mem_inst_i,
    input  req_ready_o, mem_addr_o
  );
endinterface

// File: rtl/imem_refill_ctrl.sv
// Instruction-cache refill sequencer: on a miss, reads LINE_WORDS consecutive
// words from the ROM (each presented for MEM_LAT cycles), assembles them into
// a line buffer and returns the line with a one-cycle valid pulse.
// Ports:
//   clk_i, rst_ni  : clock, synchronous active-low reset
//   bus (slave)    : miss request handshake and ROM address/data
//   line_valid_o   : one-cycle pulse, line_addr_o/line_data_o complete
//   line_addr_o    : line-aligned base address of the returned line
//   line_data_o    : line data, word 0 in bits [31:0]
//   busy_o         : refill in progress
//   refill_cnt_o   : completed refills, saturating
module imem_refill_ctrl #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  imem_refill_if.slave             bus,
  output logic                     line_valid_o,
  output logic [31:0]              line_addr_o,
  output logic [32*LINE_WORDS-1:0] line_data_o,
  output logic                     busy_o,
  output logic [CNT_W-1:0]         refill_cnt_o
);

  localparam int unsigned DATA_W = 32 * LINE_WORDS;
  localparam int unsigned IDX_W  = $clog2(LINE_WORDS);
  localparam int unsigned WAIT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(LINE_WORDS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_LAT - 1);
  localparam logic [31:0]       LINE_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_t;

  state_t              r_state, w_state;
  logic [IDX_W-1:0]    r_idx, w_idx;
  logic [WAIT_W-1:0]   r_wait, w_wait;
  logic [31:0]         r_mem_addr, w_mem_addr;
  logic [31:0]         r_line_addr, w_line_addr;
  logic [DATA_W-1:0]   r_line_data, w_line_data;
  logic [CNT_W-1:0]    r_cnt, w_cnt;
  logic                r_req_ready, r_busy, r_line_valid;

  // State and output registers; handshake flags are decoded from next state
  // so they line up with the state they describe.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_wait       <= '0;
      r_mem_addr   <= '0;
      r_line_addr  <= '0;
      r_line_data  <= '0;
      r_cnt        <= '0;
      r_req_ready  <= 1'b1;
      r_busy       <= 1'b0;
      r_line_valid <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_idx        <= w_idx;
      r_wait       <= w_wait;
      r_mem_addr   <= w_mem_addr;
      r_line_addr  <= w_line_addr;
      r_line_data  <= w_line_data;
      r_cnt        <= w_cnt;
      r_req_ready  <= (w_state == S_IDLE);
      r_busy       <= (w_state != S_IDLE);
      r_line_valid <= (w_state == S_DONE);
    end
  end

  // Next-state and datapath update.
  always_comb begin
    w_state     = r_state;
    w_idx       = r_idx;
    w_wait      = r_wait;
    w_mem_addr  = r_mem_addr;
    w_line_addr = r_line_addr;
    w_line_data = r_line_data;
    w_cnt       = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid_i) begin
          w_line_addr = bus.req_addr_i & LINE_MASK;
          w_mem_addr  = bus.req_addr_i & LINE_MASK;
          w_idx       = '0;
          w_wait      = '0;
          w_state     = S_FETCH;
        end
      end
      S_FETCH: begin
        if (MEM_LAT > 1 && r_wait != WAIT_LAST) begin
          w_wait = r_wait + WAIT_W'(1);
        end else begin
          for (int w = 0; w < int'(LINE_WORDS); w++) begin
            if (IDX_W'(w) == r_idx) w_line_data[32*w +: 32] = bus.mem_inst_i;
          end
          w_wait = '0;
          if (r_idx == IDX_LAST) begin
            w_state = S_DONE;
            // Counted on entry so the count is current while line_valid_o is high.
            if (r_cnt != '1) w_cnt = r_cnt + CNT_W'(1);
          end else begin
            w_idx      = r_idx + IDX_W'(1);
            w_mem_addr = r_mem_addr + 32'd4;
          end
        end
      end
      S_DONE:  w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
  end

  assign bus.req_ready_o = r_req_ready;
  assign bus.mem_addr_o  = r_mem_addr;
  assign line_valid_o    = r_line_valid;
  assign line_addr_o     = r_line_addr;
  assign line_data_o     = r_line_data;
  assign busy_o          = r_busy;
  assign refill_cnt_o    = r_cnt;

endmodule

// File: tb/tb_imem_refill_ctrl.sv
// Directed bench for imem_refill_ctrl: default config, MEM_LAT=3, CNT_W=2.
module tb_imem_refill_ctrl;
  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  imem_refill_if if0 ();
  imem_refill_if if1 ();
  imem_refill_if if2 ();

  // ROM model: word k holds 0xA000_0000 + k.
  assign if0.mem_inst_i = 32'hA000_0000 + (if0.mem_addr_o >> 2);
  assign if1.mem_inst_i = 32'hA000_0000 + (if1.mem_addr_o >> 2);
  assign if2.mem_inst_i = 32'hA000_0000 + (if2.mem_addr_o >> 2);

  logic         lv0, lv1, lv2, bz0, bz1, bz2;
  logic [31:0]  la0, la1, la2;
  logic [127:0] ld0, ld1, ld2;
  logic [15:0]  cn0, cn1;
  logic [1:0]   cn2;

  imem_refill_ctrl u0 (.clk_i(clk), .rst_ni(rst_n), .bus(if0), .line_valid_o(lv0),
    .line_addr_o(la0), .line_data_o(ld0), .busy_o(bz0), .refill_cnt_o(cn0));
  imem_refill_ctrl #(.MEM_LAT(3)) u1 (.clk_i(clk), .rst_ni(rst_n), .bus(if1),
    .line_valid_o(lv1), .line_addr_o(la1), .line_data_o(ld1), .busy_o(bz1),
    .refill_cnt_o(cn1));
  imem_refill_ctrl #(.CNT_W(2)) u2 (.clk_i(clk), .rst_ni(rst_n), .bus(if2),
    .line_valid_o(lv2), .line_addr_o(la2), .line_data_o(ld2), .busy_o(bz2),
    .refill_cnt_o(cn2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    if0.req_valid_i = 1'b0; if1.req_valid_i = 1'b0; if2.req_valid_i = 1'b0;
    if0.req_addr_i = '0; if1.req_addr_i = '0; if2.req_addr_i = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int pulses;
    do_reset();
    check("rst_ready", 128'(if0.req_ready_o), 128'(1));
    check("rst_busy", 128'(bz0), 128'(0));
    check("rst_valid", 128'(lv0), 128'(0));
    check("rst_maddr", 128'(if0.mem_addr_o), 128'(0));
    check("rst_laddr", 128'(la0), 128'(0));
    check("rst_data", ld0, 128'(0));
    check("rst_cnt", 128'(cn0), 128'(0));

    // 1: default refill of line 0x10
    if0.req_valid_i = 1'b1; if0.req_addr_i = 32'h14;
    tick();
    if0.req_valid_i = 1'b0; if0.req_addr_i = 32'hDEAD_BEEF;
    check("t1_ready_lo", 128'(if0.req_ready_o), 128'(0));
    check("t1_busy_hi", 128'(bz0), 128'(1));
    check("t1_maddr0", 128'(if0.mem_addr_o), 128'(32'h10));
    for (int k = 1; k < 4; k++) begin
      tick();
      check($sformatf("t1_maddr%0d", k), 128'(if0.mem_addr_o), 128'(32'h10 + 4*k));
      check($sformatf("t1_novalid%0d", k), 128'(lv0), 128'(0));
    end
    tick();
    check("t1_valid", 128'(lv0), 128'(1));
    check("t1_laddr", 128'(la0), 128'(32'h10));
    check("t1_data", ld0, {32'hA000_0007, 32'hA000_0006, 32'hA000_0005, 32'hA000_0004});
    check("t1_cnt", 128'(cn0), 128'(1));
    check("t1_done_ready", 128'(if0.req_ready_o), 128'(0));
    tick();
    check("t1_valid_pulse", 128'(lv0), 128'(0));
    check("t1_ready_back", 128'(if0.req_ready_o), 128'(1));
    check("t1_busy_lo", 128'(bz0), 128'(0));
    check("t1_data_hold", ld0, {32'hA000_0007, 32'hA000_0006, 32'hA000_0005, 32'hA000_0004});

    // 2: MEM_LAT=3, line 0x20
    do_reset();
    if1.req_valid_i = 1'b1; if1.req_addr_i = 32'h20;
    tick();
    if1.req_valid_i = 1'b0;
    for (int c = 0; c < 12; c++) begin
      check($sformatf("t2_maddr_c%0d", c), 128'(if1.mem_addr_o), 128'(32'h20 + 4*(c/3)));
      check($sformatf("t2_novalid_c%0d", c), 128'(lv1), 128'(0));
      tick();
    end
    check("t2_valid", 128'(lv1), 128'(1));
    check("t2_laddr", 128'(la1), 128'(32'h20));
    check("t2_data", ld1, {32'hA000_000B, 32'hA000_000A, 32'hA000_0009, 32'hA000_0008});

    // 3: held request, back-to-back lines 0x0 and 0x40
    do_reset();
    if0.req_valid_i = 1'b1; if0.req_addr_i = 32'h0;
    tick();
    if0.req_addr_i = 32'h40;
    repeat (4) tick();
    check("t3_valid1", 128'(lv0), 128'(1));
    check("t3_laddr1", 128'(la0), 128'(32'h0));
    tick();
    check("t3_ready_gap", 128'(if0.req_ready_o), 128'(1));
    check("t3_valid1_end", 128'(lv0), 128'(0));
    tick();
    if0.req_valid_i = 1'b0;
    check("t3_reaccept_busy", 128'(bz0), 128'(1));
    check("t3_maddr2", 128'(if0.mem_addr_o), 128'(32'h40));
    repeat (4) tick();
    check("t3_valid2", 128'(lv0), 128'(1));
    check("t3_laddr2", 128'(la0), 128'(32'h40));
    check("t3_data2", ld0, {32'hA000_0013, 32'hA000_0012, 32'hA000_0011, 32'hA000_0010});
    check("t3_cnt", 128'(cn0), 128'(2));

    // 4: request during FETCH is ignored
    do_reset();
    if0.req_valid_i = 1'b1; if0.req_addr_i = 32'h0;
    tick();
    if0.req_valid_i = 1'b0;
    tick();
    if0.req_valid_i = 1'b1; if0.req_addr_i = 32'h100;
    tick();
    if0.req_valid_i = 1'b0;
    check("t4_maddr", 128'(if0.mem_addr_o), 128'(32'h8));
    tick();
    tick();
    check("t4_valid", 128'(lv0), 128'(1));
    check("t4_laddr", 128'(la0), 128'(32'h0));
    check("t4_data", ld0, {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000});
    pulses = 0;
    repeat (10) begin tick(); if (lv0) pulses++; end
    check("t4_no_extra", 128'(pulses), 128'(0));
    check("t4_cnt", 128'(cn0), 128'(1));

    // 5: reset at FETCH index 2
    do_reset();
    if0.req_valid_i = 1'b1; if0.req_addr_i = 32'h0;
    tick();
    if0.req_valid_i = 1'b0;
    tick();
    tick();
    check("t5_pre_maddr", 128'(if0.mem_addr_o), 128'(32'h8));
    check("t5_pre_word1", 128'(ld0[63:32]), 128'(32'hA000_0001));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t5_ready", 128'(if0.req_ready_o), 128'(1));
    check("t5_busy", 128'(bz0), 128'(0));
    check("t5_data", ld0, 128'(0));
    check("t5_cnt", 128'(cn0), 128'(0));
    check("t5_maddr", 128'(if0.mem_addr_o), 128'(0));
    pulses = 0;
    repeat (10) begin tick(); if (lv0) pulses++; end
    check("t5_no_valid", 128'(pulses), 128'(0));

    // 6: CNT_W=2 saturation
    do_reset();
    for (int r = 0; r < 4; r++) begin
      if2.req_valid_i = 1'b1; if2.req_addr_i = 32'h30;
      tick();
      if2.req_valid_i = 1'b0;
      repeat (4) tick();
      check($sformatf("t6_valid%0d", r), 128'(lv2), 128'(1));
      check($sformatf("t6_cnt%0d", r), 128'(cn2), 128'((r < 3) ? r + 1 : 3));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
